// File: rtl/bresenham_pkg.sv
// Shared FSM state type and index widths for the Bresenham ray controller.
package bresenham_pkg;

    localparam int X_IDX_W    = 8;
    localparam int Y_IDX_W    = 7;
    localparam int CELL_CNT_W = 8;
    localparam int RAY_CNT_W  = 16;
    localparam int PARAM_W    = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        EVAL = 3'd2,
        EMIT = 3'd3,
        STEP = 3'd4
    } state_e;

endpackage

// File: rtl/bresenham_controller.sv
// Walks one ray cell by cell: loads the datapath x register, then alternates
// evaluate / emit / step until x reaches zero or the cell budget is spent.
module bresenham_controller
    import bresenham_pkg::*;
#(
    parameter int MAX_CELLS = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ray_valid,
    output logic                 ray_ready,
    input  logic [PARAM_W-1:0]   ray_magnitude,
    input  logic [PARAM_W-1:0]   ray_angle,
    input  logic [PARAM_W-1:0]   ray_sensor_x,
    input  logic [PARAM_W-1:0]   ray_sensor_y,
    output logic [PARAM_W-1:0]   dp_magnitude,
    output logic [PARAM_W-1:0]   dp_angle,
    output logic [PARAM_W-1:0]   dp_sensor_x,
    output logic [PARAM_W-1:0]   dp_sensor_y,
    output logic                 dp_x_source,
    output logic                 dp_x_we,
    input  logic [X_IDX_W-1:0]   dp_current_x,
    input  logic [X_IDX_W-1:0]   dp_x_index,
    input  logic [Y_IDX_W-1:0]   dp_y_index,
    output logic                 cell_valid,
    input  logic                 cell_ready,
    output logic [X_IDX_W-1:0]   cell_x,
    output logic [Y_IDX_W-1:0]   cell_y,
    output logic                 cell_occupied,
    output logic                 cell_last,
    output logic                 busy,
    output logic [RAY_CNT_W-1:0] ray_count,
    output state_e               debug_state
);

    localparam logic [CELL_CNT_W-1:0] LAST_CELL_IDX = CELL_CNT_W'(MAX_CELLS - 1);

    state_e                  state;
    state_e                  state_next;
    logic                    accept;
    logic                    handshake;
    logic                    first;
    logic [CELL_CNT_W-1:0]   cell_count;
    logic [RAY_CNT_W-1:0]    ray_count_q;

    assign ray_count   = ray_count_q;
    assign debug_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Both ports are valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; the producer holds its payload stable
    // while valid is high and ready is low, and never retracts valid.
    always_comb begin
        state_next  = state;
        ray_ready   = 1'b0;
        busy        = 1'b0;
        cell_valid  = 1'b0;
        dp_x_we     = 1'b0;
        dp_x_source = 1'b0;
        accept      = 1'b0;
        handshake   = 1'b0;

        case (state)
            IDLE: begin
                ray_ready = 1'b1;
                if (ray_valid) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                dp_x_we    = 1'b1;
                state_next = EVAL;
            end
            EVAL: begin
                state_next = EMIT;
            end
            EMIT: begin
                cell_valid = 1'b1;
                if (cell_ready) begin
                    handshake  = 1'b1;
                    state_next = cell_last ? IDLE : STEP;
                end
            end
            STEP: begin
                dp_x_we     = 1'b1;
                dp_x_source = 1'b1;
                state_next  = EVAL;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy = (state != IDLE);

        // Reset masks every strobe so an aborted ray can neither hand off a
        // cell nor move the x register in the cycle reset is sampled.
        if (reset) begin
            state_next  = IDLE;
            ray_ready   = 1'b0;
            busy        = 1'b0;
            cell_valid  = 1'b0;
            dp_x_we     = 1'b0;
            dp_x_source = 1'b0;
            accept      = 1'b0;
            handshake   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dp_magnitude  <= '0;
            dp_angle      <= '0;
            dp_sensor_x   <= '0;
            dp_sensor_y   <= '0;
            cell_x        <= '0;
            cell_y        <= '0;
            cell_occupied <= 1'b0;
            cell_last     <= 1'b0;
            first         <= 1'b0;
            cell_count    <= '0;
            ray_count_q   <= '0;
        end else begin
            if (accept) begin
                dp_magnitude <= ray_magnitude;
                dp_angle     <= ray_angle;
                dp_sensor_x  <= ray_sensor_x;
                dp_sensor_y  <= ray_sensor_y;
                cell_count   <= '0;
                first        <= 1'b1;
            end

            // The last flag is decided here, before any STEP, so x never
            // decrements past zero and the budget is never exceeded.
            if (state == EVAL) begin
                cell_x        <= dp_x_index;
                cell_y        <= dp_y_index;
                cell_occupied <= first;
                cell_last     <= (dp_current_x == '0) || (cell_count == LAST_CELL_IDX);
            end

            if (handshake) begin
                first      <= 1'b0;
                cell_count <= cell_count + CELL_CNT_W'(1);
                if (cell_last) begin
                    ray_count_q <= ray_count_q + RAY_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bresenham_controller.sv
// Bench for bresenham_controller: behavioural x-register datapath, scoreboard
// of expected cells, vector table plus directed multi-cycle sequences.
module tb_bresenham_controller;
    import bresenham_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] ray_magnitude = '0;
    logic [31:0] ray_angle     = '0;
    logic [31:0] ray_sensor_x  = '0;
    logic [31:0] ray_sensor_y  = '0;

    logic        ray_valid = 1'b0;
    logic        ray_ready;
    logic [31:0] dp_magnitude, dp_angle, dp_sensor_x, dp_sensor_y;
    logic        dp_x_source, dp_x_we;
    logic [7:0]  dp_current_x, dp_x_index;
    logic [6:0]  dp_y_index;
    logic        cell_valid;
    logic        cell_ready = 1'b1;
    logic [7:0]  cell_x;
    logic [6:0]  cell_y;
    logic        cell_occupied, cell_last, busy;
    logic [15:0] ray_count;
    state_e      debug_state;

    logic        ray_valid2 = 1'b0;
    logic        ray_ready2;
    logic [31:0] dp_magnitude2, dp_angle2, dp_sensor_x2, dp_sensor_y2;
    logic        dp_x_source2, dp_x_we2;
    logic [7:0]  dp_current_x2, dp_x_index2;
    logic [6:0]  dp_y_index2;
    logic        cell_valid2;
    logic        cell_ready2 = 1'b1;
    logic [7:0]  cell_x2;
    logic [6:0]  cell_y2;
    logic        cell_occupied2, cell_last2, busy2;
    logic [15:0] ray_count2;
    state_e      debug_state2;

    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    int          last_hs  = 0;
    int          step_seen = 0;
    logic [15:0] exp_ray_count = '0;
    logic [16:0] exp_q[$];

    always #5 clock = ~clock;

    bresenham_controller #(.MAX_CELLS(255)) u_dut (
        .clock(clock), .reset(reset),
        .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_magnitude(ray_magnitude), .ray_angle(ray_angle),
        .ray_sensor_x(ray_sensor_x), .ray_sensor_y(ray_sensor_y),
        .dp_magnitude(dp_magnitude), .dp_angle(dp_angle),
        .dp_sensor_x(dp_sensor_x), .dp_sensor_y(dp_sensor_y),
        .dp_x_source(dp_x_source), .dp_x_we(dp_x_we),
        .dp_current_x(dp_current_x), .dp_x_index(dp_x_index), .dp_y_index(dp_y_index),
        .cell_valid(cell_valid), .cell_ready(cell_ready),
        .cell_x(cell_x), .cell_y(cell_y),
        .cell_occupied(cell_occupied), .cell_last(cell_last),
        .busy(busy), .ray_count(ray_count), .debug_state(debug_state)
    );

    bresenham_controller #(.MAX_CELLS(4)) u_dut_max4 (
        .clock(clock), .reset(reset),
        .ray_valid(ray_valid2), .ray_ready(ray_ready2),
        .ray_magnitude(ray_magnitude), .ray_angle(ray_angle),
        .ray_sensor_x(ray_sensor_x), .ray_sensor_y(ray_sensor_y),
        .dp_magnitude(dp_magnitude2), .dp_angle(dp_angle2),
        .dp_sensor_x(dp_sensor_x2), .dp_sensor_y(dp_sensor_y2),
        .dp_x_source(dp_x_source2), .dp_x_we(dp_x_we2),
        .dp_current_x(dp_current_x2), .dp_x_index(dp_x_index2), .dp_y_index(dp_y_index2),
        .cell_valid(cell_valid2), .cell_ready(cell_ready2),
        .cell_x(cell_x2), .cell_y(cell_y2),
        .cell_occupied(cell_occupied2), .cell_last(cell_last2),
        .busy(busy2), .ray_count(ray_count2), .debug_state(debug_state2)
    );

    // Behavioural line datapath: x loads from the low byte of the magnitude
    // and counts down; absolute x is sensor_x plus the relative offset.
    logic [7:0] x_reg, x_reg2;
    always @(posedge clock) begin
        if (reset) begin
            x_reg  <= '0;
            x_reg2 <= '0;
        end else begin
            if (dp_x_we)  x_reg  <= dp_x_source  ? x_reg  - 8'd1 : dp_magnitude[7:0];
            if (dp_x_we2) x_reg2 <= dp_x_source2 ? x_reg2 - 8'd1 : dp_magnitude2[7:0];
        end
    end
    assign dp_current_x  = x_reg;
    assign dp_x_index    = dp_sensor_x[7:0] + x_reg;
    assign dp_y_index    = dp_sensor_y[6:0];
    assign dp_current_x2 = x_reg2;
    assign dp_x_index2   = dp_sensor_x2[7:0] + x_reg2;
    assign dp_y_index2   = dp_sensor_y2[6:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_expected(input logic [7:0] start, input logic [7:0] sx,
                                          input logic [6:0] sy, input int maxc);
        int n;
        logic [7:0] off;
        n = (int'(start) + 1 > maxc) ? maxc : int'(start) + 1;
        for (int k = 0; k < n; k++) begin
            off = start - 8'(k);
            exp_q.push_back({sx + off, sy, (k == 0), (k == n - 1)});
        end
    endfunction

    // Scoreboard side: every accepted cell is popped and compared.
    always @(negedge clock) begin
        logic [16:0] exp;
        cycle++;
        if (!reset) begin
            if (dp_x_we && dp_x_source) begin
                step_seen++;
                check("no_underflow", 32'(dp_current_x != 8'd0), 32'd1);
            end
            if (!dp_x_we) check("x_source_idle", 32'(dp_x_source), 32'd0);
            if (cell_valid && cell_ready) begin
                if (exp_q.size() == 0) begin
                    check("cell_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp = exp_q.pop_front();
                    check("cell", {15'd0, cell_x, cell_y, cell_occupied, cell_last}, {15'd0, exp});
                    if (!exp[1]) check("cell_gap", cycle - last_hs, 32'd3);
                    last_hs = cycle;
                end
            end
        end
    end

    task automatic drive_ray(input logic [7:0] start, input logic [7:0] sx,
                             input logic [6:0] sy, input bit to_max4);
        logic [31:0] t;
        @(posedge clock);
        #1;
        t = $urandom();
        ray_magnitude = {t[31:8], start};
        ray_angle     = $urandom();
        t = $urandom();
        ray_sensor_x  = {t[31:8], sx};
        t = $urandom();
        ray_sensor_y  = {t[31:7], sy};
        if (to_max4) ray_valid2 = 1'b1;
        else         ray_valid  = 1'b1;
    endtask

    task automatic accept_ray(input logic [7:0] start, input logic [7:0] sx, input logic [6:0] sy);
        int n   = 0;
        int lat = 0;
        while (!ray_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("ray_accept", 32'(ray_ready), 32'd1);
        push_expected(start, sx, sy, 255);
        @(posedge clock);
        #1;
        ray_valid = 1'b0;
        check("dp_magnitude_latch", dp_magnitude, ray_magnitude);
        check("dp_angle_latch", dp_angle, ray_angle);
        check("dp_sensor_x_latch", dp_sensor_x, ray_sensor_x);
        check("dp_sensor_y_latch", dp_sensor_y, ray_sensor_y);
        while (!cell_valid && lat < 10) begin
            @(negedge clock);
            if (!cell_valid) lat++;
        end
        check("first_cell_latency", lat, 32'd2);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("ray_done_pending", 32'(exp_q.size()), 32'd0);
        check("ray_done_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_ray(input logic [7:0] start, input logic [7:0] sx,
                           input logic [6:0] sy, input int exp_cells);
        step_seen = 0;
        drive_ray(start, sx, sy, 1'b0);
        accept_ray(start, sx, sy);
        wait_done();
        exp_ray_count++;
        check("ray_count", 32'(ray_count), 32'(exp_ray_count));
        check("step_cycles", step_seen, exp_cells - 1);
    endtask

    typedef struct {
        logic [7:0] start_x;
        logic [7:0] sensor_x;
        logic [6:0] sensor_y;
        int         exp_cells;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        int k;
        int steps2;
        logic [7:0]  r;
        logic [7:0]  ex;
        logic [31:0] mag_a, sx_a;

        r = 8'($urandom_range(2, 12));
        vecs[0] = '{8'd3, 8'd16,  7'd5,   4};
        vecs[1] = '{8'd0, 8'd100, 7'd64,  1};
        vecs[2] = '{8'd7, 8'd0,   7'd127, 8};
        vecs[3] = '{8'd1, 8'd250, 7'd0,   2};
        vecs[4] = '{r, 8'($urandom_range(0, 200)), 7'($urandom_range(0, 127)), int'(r) + 1};

        // Reset behaviour
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ray_ready", 32'(ray_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cell_valid", 32'(cell_valid), 32'd0);
        check("rst_x_we", 32'(dp_x_we), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", 32'(ray_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_state", 32'(debug_state), 32'(IDLE));
        check("post_rst_ray_count", 32'(ray_count), 32'd0);
        check("post_rst_cell", {15'd0, cell_x, cell_y, cell_occupied, cell_last}, 32'd0);
        check("post_rst_dp_mag", dp_magnitude, 32'd0);
        check("post_rst_dp_sx", dp_sensor_x, 32'd0);
        check("post_rst_dp_sy", dp_sensor_y, 32'd0);

        // Table of rays with the consumer always ready
        for (int i = 0; i < 5; i++) begin
            run_ray(vecs[i].start_x, vecs[i].sensor_x, vecs[i].sensor_y, vecs[i].exp_cells);
        end

        // Consumer stalls five cycles on the first cell
        cell_ready = 1'b0;
        drive_ray(8'd2, 8'd33, 7'd44, 1'b0);
        accept_ray(8'd2, 8'd33, 7'd44);
        for (int s = 0; s < 5; s++) begin
            check("stall_valid", 32'(cell_valid), 32'd1);
            check("stall_cell", {15'd0, cell_x, cell_y, cell_occupied, cell_last}, {15'd0, exp_q[0]});
            check("stall_x_we", 32'(dp_x_we), 32'd0);
            if (s < 4) @(negedge clock);
        end
        @(posedge clock);
        #1;
        cell_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("stall_then_step", 32'(debug_state), 32'(STEP));
        check("stall_step_we", {30'd0, dp_x_we, dp_x_source}, 32'd3);
        check("stall_remaining", 32'(exp_q.size()), 32'd2);
        wait_done();
        exp_ray_count++;
        check("stall_ray_count", 32'(ray_count), 32'(exp_ray_count));

        // A request arriving while busy waits for IDLE and leaves dp_* alone
        drive_ray(8'd4, 8'd20, 7'd9, 1'b0);
        mag_a = ray_magnitude;
        sx_a  = ray_sensor_x;
        accept_ray(8'd4, 8'd20, 7'd9);
        drive_ray(8'd2, 8'd60, 7'd33, 1'b0);
        n = 0;
        while (!ray_ready && n < 200) begin
            check("busy_dp_mag", dp_magnitude, mag_a);
            check("busy_dp_sx", dp_sensor_x, sx_a);
            @(negedge clock);
            n++;
        end
        check("busy_prev_drained", 32'(exp_q.size()), 32'd0);
        exp_ray_count++;
        check("busy_prev_count", 32'(ray_count), 32'(exp_ray_count));
        accept_ray(8'd2, 8'd60, 7'd33);
        wait_done();
        exp_ray_count++;
        check("busy_next_count", 32'(ray_count), 32'(exp_ray_count));

        // Cell budget of four truncates a ray that would be eleven cells long
        drive_ray(8'd10, 8'd40, 7'd21, 1'b1);
        n = 0;
        while (!ray_ready2 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("max4_accept", 32'(ray_ready2), 32'd1);
        @(posedge clock);
        #1;
        ray_valid2 = 1'b0;
        k = 0;
        steps2 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (dp_x_we2 && dp_x_source2) steps2++;
            if (cell_valid2 && cell_ready2) begin
                ex = 8'd50 - 8'(k);
                check("max4_cell", {15'd0, cell_x2, cell_y2, cell_occupied2, cell_last2},
                      {15'd0, ex, 7'd21, (k == 0), (k == 3)});
                k++;
            end
        end
        check("max4_cells", k, 32'd4);
        check("max4_steps", steps2, 32'd3);
        check("max4_ray_count", 32'(ray_count2), 32'd1);
        check("max4_busy", 32'(busy2), 32'd0);

        // Reset during STEP aborts the ray
        drive_ray(8'd5, 8'd30, 7'd12, 1'b0);
        accept_ray(8'd5, 8'd30, 7'd12);
        n = 0;
        while (!(dp_x_we && dp_x_source) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("abort_in_step", 32'(debug_state), 32'(STEP));
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        check("abort_state", 32'(debug_state), 32'(IDLE));
        check("abort_cell_valid", 32'(cell_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ray_ready), 32'd0);
        check("abort_ray_count", 32'(ray_count), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_ray_count = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("abort_no_cell", 32'(cell_valid), 32'd0);
        end
        run_ray(8'd1, 8'd77, 7'd3, 2);

        // Completed-ray counter wraps
        @(negedge clock);
        force u_dut.ray_count_q = 16'hFFFF;
        #1;
        release u_dut.ray_count_q;
        exp_ray_count = 16'hFFFF;
        check("wrap_preload", 32'(ray_count), 32'h0000FFFF);
        run_ray(8'd0, 8'd9, 7'd1, 1);
        check("ray_count_wrap", 32'(ray_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
